// File: rtl/spi7001_pkg.sv
// Shared SPI7001 link definitions used by the receive monitor and the driver side.
// The scan helpers map the one-hot scan lines to a scan index.
package spi7001_pkg;

  localparam int DATA_W         = 16;
  localparam int CHIPS          = 6;
  localparam int WORDS_PER_SCAN = 64;
  localparam int ADDR_W         = 10;
  localparam int VSYNC_EDGES    = 3;
  localparam int SYNC_STAGES    = 2;

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    EMIT
  } state_t;

  function automatic logic scan_is_onehot(input logic [3:0] s);
    logic r;
    case (s)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] scan_to_idx(input logic [3:0] s);
    logic [1:0] r;
    case (s)
      4'b0010: r = 2'd1;
      4'b0100: r = 2'd2;
      4'b1000: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spi7001_rx_sync.sv
// Multi-stage synchroniser for the asynchronous link inputs, with one extra
// registered copy so rise/fall pulses are one I_clk cycle wide.
module spi7001_rx_sync
  import spi7001_pkg::*;
#(
  parameter int WIDTH  = 7,
  parameter int STAGES = SYNC_STAGES
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];
  logic [WIDTH-1:0] prev_q, prev_d;

  assign sync_d[0] = din;
  for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
    assign sync_d[gi] = sync_q[gi-1];
  end
  assign prev_d = sync_q[STAGES-1];

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= sync_d[i];
      prev_q <= prev_d;
    end
  end

  assign cur  = sync_q[STAGES-1];
  assign rise = cur & ~prev_q;
  assign fall = ~cur & prev_q;

endmodule

// File: rtl/spi7001_rx_monitor.sv
// Receive-side SPI7001 link monitor: deserialises grayscale words, decodes LE
// commands and replays each data latch as a burst of sram-style writes.
module spi7001_rx_monitor
  import spi7001_pkg::*;
#(
  parameter int DATA_W         = spi7001_pkg::DATA_W,
  parameter int CHIPS          = spi7001_pkg::CHIPS,
  parameter int WORDS_PER_SCAN = spi7001_pkg::WORDS_PER_SCAN,
  parameter int ADDR_W         = spi7001_pkg::ADDR_W,
  parameter int VSYNC_EDGES    = spi7001_pkg::VSYNC_EDGES,
  parameter int SYNC_STAGES    = spi7001_pkg::SYNC_STAGES
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              LE,
  input  logic              DCLK,
  input  logic              SDI,
  input  logic [3:0]        scan,
  output logic              o_frame,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_len_err,
  output logic              o_cmd_err,
  output logic              o_scan_err
);

  localparam int BITS    = DATA_W * CHIPS;
  localparam int LATCHES = WORDS_PER_SCAN / CHIPS;
  localparam int LIDX_W  = (LATCHES > 1) ? $clog2(LATCHES) : 1;
  localparam int K_W     = (CHIPS > 1) ? $clog2(CHIPS) : 1;
  localparam int BC_W    = $clog2(BITS + 1) + 1;
  localparam int EC_W    = $clog2(VSYNC_EDGES + 1) + 1;

  logic [6:0] in_cur, in_rise, in_fall;

  spi7001_rx_sync #(
    .WIDTH (7),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .I_clk(I_clk),
    .I_rst(I_rst),
    .din  ({scan, SDI, DCLK, LE}),
    .cur  (in_cur),
    .rise (in_rise),
    .fall (in_fall)
  );

  logic       le_cur, le_rise, le_fall, dclk_rise, sdi_cur;
  logic [3:0] scan_cur;
  logic       unused_edges;

  assign le_cur       = in_cur[0];
  assign le_rise      = in_rise[0];
  assign le_fall      = in_fall[0];
  assign dclk_rise    = in_rise[1];
  assign sdi_cur      = in_cur[2];
  assign scan_cur     = in_cur[6:3];
  assign unused_edges = &{1'b0, in_cur[1], in_rise[6:2], in_fall[6:1]};

  state_t              state_q, state_d;
  logic [BITS-1:0]     shift_q, shift_d;
  logic [BITS-1:0]     buf_q, buf_d;
  logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [EC_W-1:0]     edge_cnt_q, edge_cnt_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [LIDX_W-1:0]   latch_idx_q, latch_idx_d;
  logic [1:0]          scan_idx_q, scan_idx_d;
  logic                frame_q, frame_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                len_err_q, len_err_d;
  logic                cmd_err_q, cmd_err_d;
  logic                scan_err_q, scan_err_d;

  logic       latch_scan_ok;
  logic [1:0] latch_scan_idx;

  assign latch_scan_ok  = scan_is_onehot(scan_cur);
  assign latch_scan_idx = latch_scan_ok ? scan_to_idx(scan_cur) : 2'd0;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    buf_d       = buf_q;
    bit_cnt_d   = bit_cnt_q;
    edge_cnt_d  = edge_cnt_q;
    k_d         = k_q;
    latch_idx_d = latch_idx_q;
    scan_idx_d  = scan_idx_q;
    frame_d     = 1'b0;
    wr_en_d     = 1'b0;
    wr_addr_d   = '0;
    wr_data_d   = '0;
    len_err_d   = 1'b0;
    cmd_err_d   = 1'b0;
    scan_err_d  = 1'b0;

    // The shift register runs on every DCLK rise, independent of LE and FSM.
    if (dclk_rise) begin
      shift_d = {shift_q[BITS-2:0], sdi_cur};
      if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 1'b1;
    end

    if (le_rise) begin
      edge_cnt_d = {{(EC_W-1){1'b0}}, dclk_rise};
    end else if (le_cur && dclk_rise && (edge_cnt_q != '1)) begin
      edge_cnt_d = edge_cnt_q + 1'b1;
    end

    if (le_fall) bit_cnt_d = '0;

    case (state_q)
      IDLE: begin
        if (le_rise) state_d = LATCH;
      end

      LATCH: begin
        if (le_fall) begin
          if (edge_cnt_q <= EC_W'(1)) begin
            buf_d      = shift_q;
            k_d        = '0;
            len_err_d  = (bit_cnt_q != BC_W'(BITS));
            scan_err_d = ~latch_scan_ok;
            scan_idx_d = latch_scan_idx;
            if (latch_scan_idx != scan_idx_q) latch_idx_d = '0;
            state_d    = EMIT;
          end else if (edge_cnt_q >= EC_W'(VSYNC_EDGES)) begin
            frame_d     = 1'b1;
            latch_idx_d = '0;
            state_d     = IDLE;
          end else begin
            cmd_err_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end

      EMIT: begin
        wr_en_d   = 1'b1;
        wr_addr_d = ADDR_W'(scan_idx_q) * ADDR_W'(WORDS_PER_SCAN)
                  + ADDR_W'(latch_idx_q) * ADDR_W'(CHIPS)
                  + ADDR_W'(k_q);
        wr_data_d = buf_q[BITS-1 -: DATA_W];
        buf_d     = buf_q << DATA_W;
        // A latch arriving while the previous burst is still draining is dropped.
        if (le_fall) cmd_err_d = 1'b1;
        if (k_q == K_W'(CHIPS - 1)) begin
          latch_idx_d = (latch_idx_q == LIDX_W'(LATCHES - 1)) ? '0 : latch_idx_q + 1'b1;
          state_d     = le_cur ? LATCH : IDLE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      buf_q       <= '0;
      bit_cnt_q   <= '0;
      edge_cnt_q  <= '0;
      k_q         <= '0;
      latch_idx_q <= '0;
      scan_idx_q  <= '0;
      frame_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      len_err_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
      scan_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      buf_q       <= buf_d;
      bit_cnt_q   <= bit_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      k_q         <= k_d;
      latch_idx_q <= latch_idx_d;
      scan_idx_q  <= scan_idx_d;
      frame_q     <= frame_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      len_err_q   <= len_err_d;
      cmd_err_q   <= cmd_err_d;
      scan_err_q  <= scan_err_d;
    end
  end

  assign o_frame    = frame_q;
  assign o_wr_en    = wr_en_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_len_err  = len_err_q;
  assign o_cmd_err  = cmd_err_q;
  assign o_scan_err = scan_err_q;

endmodule

// File: tb/tb_spi7001_rx_monitor.sv
// Directed-plus-random bench for spi7001_rx_monitor; a queue-based model of the
// link rules predicts every write and every pulse count.
module tb_spi7001_rx_monitor;

  localparam int DW    = 16;
  localparam int NCH   = 6;
  localparam int WPS   = 64;
  localparam int AW    = 10;
  localparam int NBITS = DW * NCH;

  logic          I_clk = 1'b0;
  logic          I_rst;
  logic          LE, DCLK, SDI;
  logic [3:0]    scan_i;
  logic          o_frame, o_wr_en, o_len_err, o_cmd_err, o_scan_err;
  logic [AW-1:0] o_wr_addr;
  logic [DW-1:0] o_wr_data;

  always #5 I_clk = ~I_clk;

  spi7001_rx_monitor dut (
    .I_clk     (I_clk),
    .I_rst     (I_rst),
    .LE        (LE),
    .DCLK      (DCLK),
    .SDI       (SDI),
    .scan      (scan_i),
    .o_frame   (o_frame),
    .o_wr_en   (o_wr_en),
    .o_wr_addr (o_wr_addr),
    .o_wr_data (o_wr_data),
    .o_len_err (o_len_err),
    .o_cmd_err (o_cmd_err),
    .o_scan_err(o_scan_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // observed side
  logic [31:0] got_a[$], got_d[$];
  int wr_cycles = 0, frame_seen = 0, len_seen = 0, cmd_seen = 0, scan_seen = 0;

  // model side
  bit          hist[$];
  int          since_latch = 0, m_latch = 0, m_scan = 0;
  int          exp_frame = 0, exp_len = 0, exp_cmd = 0, exp_scan = 0;
  logic [31:0] exp_a[$], exp_d[$];

  always @(negedge I_clk) begin
    if (o_wr_en === 1'b1) begin
      got_a.push_back(32'(o_wr_addr));
      got_d.push_back(32'(o_wr_data));
      wr_cycles++;
    end
    if (o_frame === 1'b1)    frame_seen++;
    if (o_len_err === 1'b1)  len_seen++;
    if (o_cmd_err === 1'b1)  cmd_seen++;
    if (o_scan_err === 1'b1) scan_seen++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge I_clk);
  endtask

  task automatic send_bit(input bit b);
    SDI = b;
    wait_n(3);
    DCLK = 1'b1;
    hist.push_back(b);
    if (hist.size() > NBITS) void'(hist.pop_front());
    since_latch++;
    wait_n(3);
    DCLK = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    for (int b = DW - 1; b >= 0; b--) send_bit(w[b]);
  endtask

  task automatic send_random(input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(bit'($urandom_range(0, 1)));
  endtask

  // Apply the LE-fall decode rules to the model state.
  task automatic model_latch(input int n_edges);
    int          idx, base, pos;
    logic [31:0] w;
    if (n_edges <= 1) begin
      idx = 0;
      if ($countones(scan_i) == 1) begin
        for (int i = 0; i < 4; i++) if (scan_i[i]) idx = i;
      end else begin
        exp_scan++;
      end
      if (since_latch != NBITS) exp_len++;
      if (idx != m_scan) m_latch = 0;
      m_scan = idx;
      for (int k = 0; k < NCH; k++) begin
        w    = 0;
        base = hist.size() - NBITS + DW * k;
        for (int b = 0; b < DW; b++) begin
          pos = base + b;
          w   = {w[30:0], (pos >= 0) ? hist[pos] : 1'b0};
        end
        exp_a.push_back(32'((idx * WPS + m_latch * NCH + k) % (1 << AW)));
        exp_d.push_back(w);
      end
      m_latch = (m_latch + 1) % (WPS / NCH);
    end else if (n_edges >= 3) begin
      exp_frame++;
      m_latch = 0;
    end else begin
      exp_cmd++;
    end
    since_latch = 0;
  endtask

  task automatic window(input string tag, input int n_edges);
    int lat;
    LE = 1'b1;
    wait_n(3);
    send_random(n_edges);
    wait_n(3);
    LE = 1'b0;
    model_latch(n_edges);
    if (n_edges <= 1) begin
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
        @(negedge I_clk);
        if (o_wr_en === 1'b1) begin
          lat = i;
          break;
        end
      end
      chk({tag, "_latency"}, 32'(lat), 32'd4);
    end
    wait_n(14);
  endtask

  task automatic flush(input string tag);
    logic [31:0] ga, gd, ea, ed;
    while (exp_a.size() > 0) begin
      if (got_a.size() == 0) begin
        chk({tag, "_wrcount"}, 32'(got_a.size()), 32'(exp_a.size()));
        exp_a.delete();
        exp_d.delete();
      end else begin
        ga = got_a.pop_front();
        gd = got_d.pop_front();
        ea = exp_a.pop_front();
        ed = exp_d.pop_front();
        $display("wr %s addr=%0d data=%04h (model addr=%0d data=%04h)", tag, ga, gd, ea, ed);
        chk({tag, "_addr"}, ga, ea);
        chk({tag, "_data"}, gd, ed);
      end
    end
    chk({tag, "_extra_wr"}, 32'(got_a.size()), 32'd0);
    got_a.delete();
    got_d.delete();
    chk({tag, "_frame"}, 32'(frame_seen), 32'(exp_frame));
    chk({tag, "_len_err"}, 32'(len_seen), 32'(exp_len));
    chk({tag, "_cmd_err"}, 32'(cmd_seen), 32'(exp_cmd));
    chk({tag, "_scan_err"}, 32'(scan_seen), 32'(exp_scan));
  endtask

  initial begin
    bit found;
    I_rst  = 1'b1;
    LE     = 1'b0;
    DCLK   = 1'b0;
    SDI    = 1'b0;
    scan_i = 4'b0001;

    // reset with DCLK toggling
    for (int i = 0; i < 5; i++) begin
      @(negedge I_clk);
      DCLK = ~DCLK;
    end
    DCLK = 1'b0;
    @(negedge I_clk);
    chk("rst_frame", 32'(o_frame), 32'd0);
    chk("rst_wr_en", 32'(o_wr_en), 32'd0);
    chk("rst_wr_addr", 32'(o_wr_addr), 32'd0);
    chk("rst_wr_data", 32'(o_wr_data), 32'd0);
    chk("rst_len_err", 32'(o_len_err), 32'd0);
    chk("rst_cmd_err", 32'(o_cmd_err), 32'd0);
    chk("rst_scan_err", 32'(o_scan_err), 32'd0);
    I_rst = 1'b0;
    wait_n(10);
    chk("post_rst_wr_cycles", 32'(wr_cycles), 32'd0);

    // vsync: 3 DCLK rises inside LE
    window("vsync", 3);
    flush("vsync");

    // directed data latch on scan2
    scan_i = 4'b0010;
    for (int k = 1; k <= NCH; k++) send_word(16'(k * 16'h1111));
    window("data", 0);
    flush("data");

    // random latches on random scan lines
    for (int r = 0; r < 3; r++) begin
      scan_i = 4'(1 << $urandom_range(0, 3));
      send_random(NBITS);
      window("rand", 0);
      flush("rand");
    end

    // short frame still emits
    send_random(NBITS - 1);
    window("len", 0);
    flush("len");

    // 2-edge LE window
    window("cmd", 2);
    flush("cmd");

    // non-one-hot scan at latch
    scan_i = 4'b0011;
    send_random(NBITS);
    window("scanerr", 0);
    flush("scanerr");

    // latch index wrap on scan1
    scan_i = 4'b0001;
    window("vsync2", 3);
    flush("vsync2");
    for (int r = 0; r < 11; r++) begin
      send_random(NBITS);
      window("wrap", 0);
      flush("wrap");
    end

    // reset in the middle of a write burst
    send_random(NBITS);
    LE = 1'b1;
    wait_n(6);
    LE = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge I_clk);
      if (o_wr_en === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk("mid_emit_seen", 32'(found), 32'd1);
    I_rst = 1'b1;
    @(negedge I_clk);
    chk("mid_emit_wr_drop", 32'(o_wr_en), 32'd0);
    wait_n(3);
    I_rst = 1'b0;
    got_a.delete();
    got_d.delete();
    hist.delete();
    since_latch = 0;
    m_latch     = 0;
    m_scan      = 0;
    wait_n(4);
    window("resume_vsync", 3);
    send_random(NBITS);
    window("resume", 0);
    flush("resume");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
